// File: rtl/first_nios2_system_sysid_checker.sv
// ============================================================================
// Module   : first_nios2_system_sysid_checker
// Purpose  : Reads the sysid ID and timestamp words over Avalon-MM and
//            compares them against the expected build values.
// Revision : 1.0
// ============================================================================
`default_nettype none

module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h56A6_A3EC,
  parameter int          TIMEOUT_CYCLES     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic        addr_q;
  logic        read_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        timeout_q;
  logic [31:0] id_q;
  logic [31:0] ts_q;
  logic [15:0] cnt_q;
  logic        stall_expired;

  // True on the stall cycle that brings the counter up to the limit.
  assign stall_expired = avm_waitrequest && (({1'b0, cnt_q} + 17'd1) == TIMEOUT_LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      id_q      <= 32'h0;
      ts_q      <= 32'h0;
      cnt_q     <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RD_ID;
            addr_q    <= 1'b0;
            read_q    <= 1'b1;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= 16'h0;
          end
        end
        RD_ID: begin
          if (!avm_waitrequest) begin
            id_q    <= avm_readdata;
            addr_q  <= 1'b1;
            cnt_q   <= 16'h0;
            state_q <= RD_TS;
          end else if (stall_expired) begin
            read_q    <= 1'b0;
            addr_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            state_q   <= FINISH;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RD_TS: begin
          if (!avm_waitrequest) begin
            ts_q    <= avm_readdata;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
            state_q <= FINISH;
          end else if (stall_expired) begin
            read_q    <= 1'b0;
            addr_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            state_q   <= FINISH;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

`default_nettype wire

// File: tb/tb_first_nios2_system_sysid_checker.sv
// ============================================================================
// Module   : tb_first_nios2_system_sysid_checker
// Purpose  : Directed self-checking bench for the sysid checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_first_nios2_system_sysid_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        wr;
  logic        wr_to;
  logic [31:0] id_word;
  logic [31:0] ts_word;
  logic [31:0] rdata;
  logic [31:0] rdata_to;

  wire        addr, rd, busy, done, pass, tmo;
  wire [31:0] idv, tsv;
  wire        addr_t, rd_t, busy_t, done_t, pass_t, tmo_t;
  wire [31:0] idv_t, tsv_t;

  int n_cmp = 0;
  int n_mis = 0;
  int n_done;

  always #5 clock = ~clock;

  // Slave model: junk on the bus while stalled so stray captures are visible.
  assign rdata    = wr ? 32'hBAD0_BAD0 : (addr ? ts_word : id_word);
  assign rdata_to = wr_to ? 32'h1234_5678 : 32'hDEAD_BEEF;

  first_nios2_system_sysid_checker dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(addr), .avm_read(rd), .avm_waitrequest(wr), .avm_readdata(rdata),
    .busy(busy), .done(done), .pass(pass), .timeout(tmo),
    .id_value(idv), .ts_value(tsv)
  );

  first_nios2_system_sysid_checker #(
    .EXPECTED_ID(32'hDEAD_BEEF), .EXPECTED_TIMESTAMP(32'hDEAD_BEEF), .TIMEOUT_CYCLES(4)
  ) dut_to (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(addr_t), .avm_read(rd_t), .avm_waitrequest(wr_to), .avm_readdata(rdata_to),
    .busy(busy_t), .done(done_t), .pass(pass_t), .timeout(tmo_t),
    .id_value(idv_t), .ts_value(tsv_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wr = 1'b0; wr_to = 1'b0;
    id_word = 32'h0; ts_word = 32'h56A6_A3EC;
    repeat (3) tick();
    chk("rst_read0", {31'b0, rd}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_flags", {28'b0, addr, done, pass, tmo}, 0);
    chk("rst_id", idv, 0);
    chk("rst_ts", tsv, 0);
    reset = 1'b0;
    repeat (6) tick();

    // Zero-wait nominal check: start at cycle N, done at N+3.
    start = 1'b1; tick(); start = 1'b0;
    chk("nom_rd_id", {29'b0, rd, addr, busy}, 32'b101);
    tick();
    chk("nom_rd_ts", {29'b0, rd, addr, busy}, 32'b111);
    chk("nom_idv", idv, 32'h0);
    tick();
    chk("nom_fin", {28'b0, rd, busy, done, pass}, 32'b0011);
    chk("nom_tmo", {31'b0, tmo}, 0);
    chk("nom_ts", tsv, 32'h56A6_A3EC);
    chk("to_first_pass", {30'b0, pass_t, tmo_t}, 32'b10);
    chk("to_first_id", idv_t, 32'hDEAD_BEEF);
    tick();
    chk("nom_hold", {30'b0, done, pass}, 32'b01);

    // Wrong timestamp.
    ts_word = 32'h56A6_A3ED;
    start = 1'b1; tick(); start = 1'b0;
    chk("bad_clear", {30'b0, pass, tmo}, 0);
    tick(); tick();
    chk("bad_fin", {29'b0, done, pass, tmo}, 32'b100);
    chk("bad_ts", tsv, 32'h56A6_A3ED);
    ts_word = 32'h56A6_A3EC;
    tick();

    // Three stall cycles per read: done at start+9.
    start = 1'b1; wr = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("st_id_hold", {30'b0, rd, addr}, 32'b10);
      tick();
    end
    wr = 1'b0;
    chk("st_id_acc", {30'b0, rd, addr}, 32'b10);
    tick(); wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("st_ts_hold", {30'b0, rd, addr}, 32'b11);
      tick();
    end
    wr = 1'b0;
    chk("st_ts_acc", {30'b0, rd, addr}, 32'b11);
    tick();
    chk("st_fin", {29'b0, done, pass, tmo}, 32'b110);
    chk("st_ts", tsv, 32'h56A6_A3EC);
    tick();

    // Timeout on the 4-cycle instance with waitrequest stuck high.
    wr_to = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("to_clear", {30'b0, pass_t, tmo_t}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("to_read", {31'b0, rd_t}, 1);
      tick();
    end
    chk("to_fin", {27'b0, rd_t, busy_t, done_t, pass_t, tmo_t}, 32'b00101);
    chk("to_id", idv_t, 32'hDEAD_BEEF);
    tick();
    chk("to_hold", {30'b0, pass_t, tmo_t}, 32'b01);
    wr_to = 1'b0;
    repeat (2) tick();

    // Start re-pulsed during RD_TS is ignored.
    n_done = 0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done) n_done++;
      tick(); start = 1'b0;
    end
    chk("repulse_done_cnt", n_done, 1);

    // Reset while in RD_ID aborts with no done pulse.
    n_done = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("rr_in_rdid", {30'b0, rd, busy}, 32'b11);
    reset = 1'b1; start = 1'b1; tick();
    chk("rr_outs", {26'b0, rd, addr, busy, done, pass, tmo}, 0);
    chk("rr_vals", idv | tsv, 0);
    tick(); reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) n_done++;
      tick();
    end
    chk("rr_idle_after", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/first_nios2_system_sysid_checker.md
FIRST_NIOS2_SYSTEM_SYSID_CHECKER -- requirements
Module: first_nios2_system_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, value the ID word (address 0) must return.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'h56A6_A3EC (1453761516), value the timestamp word (address 1) must return.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, wait-stall cycles allowed per read, legal range 1..65535.
REQ-004 SHALL have port clock, input, 1, single clock for all logic, rising edge.
REQ-005 SHALL have port reset, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port start, input, 1, one-cycle request to run a check.
REQ-007 SHALL have port avm_address, output, 1, Avalon-MM word address to the sysid slave.
REQ-008 SHALL have port avm_read, output, 1, Avalon-MM read strobe.
REQ-009 SHALL have port avm_waitrequest, input, 1, slave stall; tie low for a zero-wait slave.
REQ-010 SHALL have port avm_readdata, input, 32, slave read data, valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-011 SHALL have port busy, output, 1, check in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at check completion.
REQ-013 SHALL have port pass, output, 1, last check matched both expected words.
REQ-014 SHALL have port timeout, output, 1, last check aborted on stall timeout.
REQ-015 SHALL have port id_value, output, 32, captured ID word.
REQ-016 SHALL have port ts_value, output, 32, captured timestamp word.

Function
REQ-017 SHALL implement states IDLE, RD_ID, RD_TS, FINISH; all outputs registered.
REQ-018 IDLE: start=1 SHALL move to RD_ID next cycle; start=0 stays IDLE.
REQ-019 RD_ID SHALL drive avm_read=1, avm_address=0, busy=1; hold address and read stable while avm_waitrequest=1.
REQ-020 RD_ID accept cycle (avm_waitrequest=0) SHALL capture avm_readdata into id_value and move to RD_TS next cycle, with avm_read staying 1 and avm_address changing to 1.
REQ-021 RD_TS SHALL drive avm_read=1, avm_address=1, busy=1; accept cycle SHALL capture ts_value and move to FINISH.
REQ-022 FINISH SHALL last one cycle: avm_read=0, busy=0, done=1; then IDLE.
REQ-023 On done: pass SHALL be 1 iff id_value==EXPECTED_ID and ts_value==EXPECTED_TIMESTAMP and timeout=0; pass and timeout SHALL hold until the next start is accepted.
REQ-024 Accepting start SHALL clear pass and timeout; id_value and ts_value SHALL keep old values until overwritten.
REQ-025 A 16-bit stall counter SHALL clear on entry to RD_ID and RD_TS and increment each cycle avm_read=1 and avm_waitrequest=1.
REQ-026 When the counter equals TIMEOUT_CYCLES with avm_waitrequest still 1, the block SHALL drop avm_read next cycle, set timeout=1, pass=0, enter FINISH; the pending word is not captured.
REQ-027 start while busy=1 or in FINISH SHALL be ignored, not queued.
REQ-028 Zero-wait slave: start at cycle N -> reads at N+1 (addr 0), N+2 (addr 1), done at N+3; nominal latency 3 cycles.
REQ-029 avm_readdata SHALL be ignored outside accept cycles.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, timeout=0, id_value=0, ts_value=0, counter=0.
REQ-031 reset mid-transaction SHALL abort without a done pulse; first cycle after reset release is IDLE; start during reset ignored.

Verification
REQ-032 Zero-wait slave returns 0 / 32'h56A6_A3EC; start pulse at cycle 10 -> reads cycles 11-12, done=1 cycle 13, pass=1, timeout=0, ts_value=32'h56A6_A3EC.
REQ-033 Slave returns timestamp 32'h56A6_A3ED -> done after 3 cycles, pass=0, timeout=0, ts_value=32'h56A6_A3ED.
REQ-034 waitrequest high 3 cycles on each read -> address/read stable while stalled, done at start+9, pass=1.
REQ-035 TIMEOUT_CYCLES=4, waitrequest held high -> avm_read drops after 4 stall cycles in RD_ID, done=1, timeout=1, pass=0, id_value unchanged.
REQ-036 start re-pulsed during RD_TS -> ignored, exactly one done pulse; reset asserted in RD_ID -> all outputs 0 next cycle, no done.
